// File: rtl/jb_srx_path_ctrl_v2_if.sv
// SRX path controller bus bundle: DPD request stream, per-antenna
// ADC streams and the selected DPD SRX output stream.
interface jb_srx_path_ctrl_v2_if #(
  parameter int N_ANTENNAS = 8,
  parameter int DATA_W     = 32
);
  logic                         ctrl_tvalid;
  logic                         ctrl_tready;
  logic [7:0]                   ctrl_tdata;
  logic [N_ANTENNAS*DATA_W-1:0] srx_tdata;
  logic [N_ANTENNAS-1:0]        srx_tvalid;
  logic [N_ANTENNAS-1:0]        srx_tready;
  logic [DATA_W-1:0]            dpd_tdata;
  logic                         dpd_tvalid;
  logic                         dpd_tready;
  logic [7:0]                   dpd_tuser;

  modport master (
    output ctrl_tvalid,
    output ctrl_tdata,
    output srx_tdata,
    output srx_tvalid,
    output dpd_tready,
    input  ctrl_tready,
    input  srx_tready,
    input  dpd_tdata,
    input  dpd_tvalid,
    input  dpd_tuser
  );

  modport slave (
    input  ctrl_tvalid,
    input  ctrl_tdata,
    input  srx_tdata,
    input  srx_tvalid,
    input  dpd_tready,
    output ctrl_tready,
    output srx_tready,
    output dpd_tdata,
    output dpd_tvalid,
    output dpd_tuser
  );
endinterface

// File: rtl/jb_srx_path_ctrl_v2.sv
// SRX observation-path controller: request FSM, RF switch sequencing, data mux.
// Define SRX_BLANK_EN to zero dpd_tdata while a switch is in flight.
module jb_srx_path_ctrl_v2 #(
  parameter int N_ANTENNAS = 8,
  parameter int DATA_W     = 32,
  parameter int DLY_W      = 16
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  jb_srx_path_ctrl_v2_if.slave          bus,
  input  logic [DLY_W-1:0]              sw_delay,
  input  logic                          ovr_en,
  input  logic [$clog2(N_ANTENNAS)-1:0] ovr_ant,
  input  logic                          ovr_path,
  output logic [$clog2(N_ANTENNAS)-1:0] ant_sel,
  output logic                          path_sel,
  output logic [$clog2(N_ANTENNAS)-1:0] wrssi_ant,
  output logic                          busy,
  output logic [7:0]                    err_cnt
);
  localparam int ANT_W = $clog2(N_ANTENNAS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SWITCH = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_GRANT  = 2'd3;

  logic [1:0]       state;
  logic [DLY_W-1:0] cnt;
  logic [ANT_W-1:0] sel_ant;
  logic             sel_path;
  logic [ANT_W-1:0] tuser_ant;
  logic [ANT_W-1:0] ant_q;
  logic             path_q;
  logic [7:0]       err_q;

  logic [3:0]       req_type;
  logic [3:0]       req_ant;
  logic             hs;
  logic             is_path;
  logic             is_nop;
  logic             ant_ok;
  logic             ovr_ok;

  logic [DATA_W-1:0] mux_data;
  logic              mux_valid;

  assign req_type = bus.ctrl_tdata[7:4];
  assign req_ant  = bus.ctrl_tdata[3:0];

  assign bus.ctrl_tready = axis_aresetn && (state == S_IDLE);
  assign hs = bus.ctrl_tvalid && bus.ctrl_tready;

  assign is_path = (req_type == 4'h0) || (req_type == 4'h2);
  assign is_nop  = (req_type == 4'h1) || (req_type == 4'hF);
  assign ant_ok  = {1'b0, req_ant} < 5'(N_ANTENNAS);
  assign ovr_ok  = {1'b0, ovr_ant} < (ANT_W+1)'(N_ANTENNAS);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel_ant   <= '0;
      sel_path  <= 1'b0;
      tuser_ant <= '0;
      err_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (hs) begin
            unique case (1'b1)
              is_path && ant_ok: begin
                state    <= S_SWITCH;
                sel_ant  <= req_ant[ANT_W-1:0];
                sel_path <= (req_type == 4'h2);
              end
              is_nop: ;
              default: begin
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
              end
            endcase
          end
        end
        S_SWITCH: begin
          cnt   <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == sw_delay) state <= S_GRANT;
          else cnt <= cnt + 1'b1;
        end
        S_GRANT: begin
          tuser_ant <= sel_ant;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Out-of-range override antenna keeps the switch where it was
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      ant_q  <= '0;
      path_q <= 1'b0;
    end else if (ovr_en) begin
      if (ovr_ok) ant_q <= ovr_ant;
      path_q <= ovr_path;
    end else begin
      ant_q  <= sel_ant;
      path_q <= sel_path;
    end
  end

  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int i = 0; i < N_ANTENNAS; i++) begin
      if (tuser_ant == ANT_W'(i)) begin
        mux_data  = bus.srx_tdata[i*DATA_W +: DATA_W];
        mux_valid = bus.srx_tvalid[i];
      end
    end
  end

  assign busy = (state != S_IDLE);

`ifdef SRX_BLANK_EN
  assign bus.dpd_tdata = busy ? '0 : mux_data;
`else
  assign bus.dpd_tdata = mux_data;
`endif

  assign bus.dpd_tvalid = mux_valid;
  assign bus.dpd_tuser  = 8'(tuser_ant);
  assign bus.srx_tready = {N_ANTENNAS{bus.dpd_tready}};

  assign ant_sel   = ant_q;
  assign path_sel  = path_q;
  assign wrssi_ant = ant_q;
  assign err_cnt   = err_q;
endmodule

// File: tb/tb_jb_srx_path_ctrl_v2.sv
// Bench for jb_srx_path_ctrl_v2: directed steps then random traffic,
// all checked against a cycle-count reference model.
module tb_jb_srx_path_ctrl_v2;
  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int DLY_W = 16;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jb_srx_path_ctrl_v2_if #(.N_ANTENNAS(N), .DATA_W(DW)) bus ();

  logic [DLY_W-1:0] sw_delay;
  logic             ovr_en;
  logic [AW-1:0]    ovr_ant;
  logic             ovr_path;
  logic [AW-1:0]    ant_sel;
  logic             path_sel;
  logic [AW-1:0]    wrssi_ant;
  logic             busy;
  logic [7:0]       err_cnt;

  jb_srx_path_ctrl_v2 #(
    .N_ANTENNAS(N), .DATA_W(DW), .DLY_W(DLY_W)
  ) dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst_n),
    .bus         (bus),
    .sw_delay    (sw_delay),
    .ovr_en      (ovr_en),
    .ovr_ant     (ovr_ant),
    .ovr_path    (ovr_path),
    .ant_sel     (ant_sel),
    .path_sel    (path_sel),
    .wrssi_ant   (wrssi_ant),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a request costs sw_delay+3 busy cycles
  int          m_left  = 0;
  logic [AW-1:0] m_sel = '0;
  logic          m_selp = 1'b0;
  logic [AW-1:0] m_tuser = '0;
  logic [AW-1:0] m_ant = '0;
  logic          m_path = 1'b0;
  logic          m_acc = 1'b0;
  int            m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_sel = '0; m_selp = 1'b0;
      m_tuser = '0; m_ant = '0; m_path = 1'b0;
      m_acc = 1'b0; m_err = 0;
    end else begin
      automatic logic [AW-1:0] os = m_sel;
      automatic logic op = m_selp;
      automatic int typ = int'(bus.ctrl_tdata[7:4]);
      automatic int an = int'(bus.ctrl_tdata[3:0]);
      m_acc = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_tuser = m_sel;
      end else if (bus.ctrl_tvalid) begin
        m_acc = 1'b1;
        if ((typ == 0 || typ == 2) && an < N) begin
          m_sel  = AW'(an);
          m_selp = (typ == 2);
          m_left = int'(sw_delay) + 3;
        end else if (!(typ == 1 || typ == 15)) begin
          if (m_err < 255) m_err++;
        end
      end
      if (ovr_en) begin
        if (int'(ovr_ant) < N) m_ant = ovr_ant;
        m_path = ovr_path;
      end else begin
        m_ant  = os;
        m_path = op;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] exp_data;
    exp_data = bus.srx_tdata[m_tuser*DW +: DW];
`ifdef SRX_BLANK_EN
    if (m_left > 0) exp_data = '0;
`endif
    chk("ctrl_tready", bus.ctrl_tready, rst_n && m_left == 0);
    chk("busy", busy, m_left > 0);
    chk("ant_sel", ant_sel, m_ant);
    chk("path_sel", path_sel, m_path);
    chk("wrssi_ant", wrssi_ant, m_ant);
    chk("dpd_tuser", bus.dpd_tuser, {5'd0, m_tuser});
    chk("err_cnt", err_cnt, m_err);
    chk("dpd_tdata", bus.dpd_tdata, exp_data);
    chk("dpd_tvalid", bus.dpd_tvalid, bus.srx_tvalid[m_tuser]);
    chk("srx_tready", bus.srx_tready, {N{bus.dpd_tready}});
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic rnd_srx();
    for (int i = 0; i < N; i++) bus.srx_tdata[i*DW +: DW] = $urandom;
    bus.srx_tvalid = N'($urandom);
    bus.dpd_tready = 1'($urandom);
  endtask

  function automatic logic [7:0] pick_req();
    logic [3:0] a;
    a = 4'($urandom);
    case ($urandom % 5)
      0: return {4'h0, a};
      1: return {4'h2, a};
      2: return {4'h1, a};
      3: return {4'hF, a};
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    bus.ctrl_tvalid = 1'b0;
    bus.ctrl_tdata  = 8'h00;
    sw_delay = '0;
    ovr_en   = 1'b0;
    ovr_ant  = '0;
    ovr_path = 1'b0;
    rnd_srx();
    bus.dpd_tready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check_all();
    chk("rst_tready", bus.ctrl_tready, 1'b0);
    rst_n = 1'b1;
    #1 check_all();
    chk("rel_tuser", bus.dpd_tuser, 8'd0);
    chk("rel_busy", busy, 1'b0);

    // request ant 5, settle 10
    @(negedge clk);
    sw_delay = 16'd10;
    bus.ctrl_tvalid = 1'b1;
    bus.ctrl_tdata  = 8'h05;
    cyc();
    bus.ctrl_tvalid = 1'b0;
    chk("t1_busy0", busy, 1'b1);
    cyc();
    chk("t1_ant_sel", ant_sel, 3'd5);
    repeat (11) cyc();
    chk("t1_busy12", busy, 1'b1);
    chk("t1_tuser_old", bus.dpd_tuser, 8'd0);
    cyc();
    chk("t1_busy13", busy, 1'b0);
    chk("t1_tuser", bus.dpd_tuser, 8'd5);
    chk("t1_data", bus.dpd_tdata, bus.srx_tdata[5*DW +: DW]);

    // consumed no-op requests
    bus.ctrl_tvalid = 1'b1;
    bus.ctrl_tdata  = 8'h13;
    cyc();
    bus.ctrl_tdata  = 8'hF3;
    cyc();
    bus.ctrl_tvalid = 1'b0;
    cyc();
    chk("t3_err", err_cnt, 8'd0);
    chk("t3_tuser", bus.dpd_tuser, 8'd5);
    chk("t3_ant", ant_sel, 3'd5);

    // out-of-range antenna, then saturation
    bus.ctrl_tvalid = 1'b1;
    bus.ctrl_tdata  = 8'h2A;
    cyc();
    chk("t2_err1", err_cnt, 8'd1);
    chk("t2_busy", busy, 1'b0);
    repeat (300) cyc();
    bus.ctrl_tvalid = 1'b0;
    chk("t2_err_sat", err_cnt, 8'd255);

    // second request held through settle
    sw_delay = 16'd3;
    bus.ctrl_tvalid = 1'b1;
    bus.ctrl_tdata  = 8'h07;
    cyc();
    bus.ctrl_tdata  = 8'h02;
    repeat (5) begin
      cyc();
      chk("t4_hold", bus.ctrl_tready, 1'b0);
    end
    cyc();
    chk("t4_tuser7", bus.dpd_tuser, 8'd7);
    chk("t4_ready", bus.ctrl_tready, 1'b1);
    cyc();
    bus.ctrl_tvalid = 1'b0;
    chk("t4_accept2", busy, 1'b1);
    repeat (6) cyc();
    chk("t4_tuser2", bus.dpd_tuser, 8'd2);

    // switch override
    ovr_en = 1'b1; ovr_ant = 3'd6; ovr_path = 1'b1;
    cyc();
    chk("t5_ovr_ant", ant_sel, 3'd6);
    chk("t5_ovr_path", path_sel, 1'b1);
    chk("t5_tuser", bus.dpd_tuser, 8'd2);
    ovr_en = 1'b0;
    cyc();
    chk("t5_rest_ant", ant_sel, 3'd2);
    chk("t5_rest_path", path_sel, 1'b0);

    // reset during settle
    sw_delay = 16'd8;
    bus.ctrl_tvalid = 1'b1;
    bus.ctrl_tdata  = 8'h24;
    cyc();
    bus.ctrl_tvalid = 1'b0;
    repeat (4) cyc();
    chk("t6_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 check_all();
    chk("t6_tready", bus.ctrl_tready, 1'b0);
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_ant", ant_sel, 3'd0);
    chk("t6_tuser", bus.dpd_tuser, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all();

    // random traffic
    repeat (3000) begin
      rnd_srx();
      ovr_en   = ($urandom % 8) == 0;
      ovr_ant  = AW'($urandom);
      ovr_path = 1'($urandom);
      if (m_left == 0) sw_delay = DLY_W'($urandom % 6);
      if (!bus.ctrl_tvalid || m_acc) begin
        bus.ctrl_tvalid = 1'($urandom);
        bus.ctrl_tdata  = pick_req();
      end
      if ($urandom % 400 == 0) begin
        rst_n = 1'b0;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
